// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU share arbiter: operand/op types, the request record
// and the combinational core ALU evaluation used between the pipeline registers.
package alu_share_arbiter_pkg;

  localparam int XLEN            = 64;
  localparam int ALU_ARB_MAX_REQ = 4;

  typedef logic [XLEN-1:0] data_t;

  typedef enum logic [3:0] {
    ALU_DEFAULT = 4'd0,
    ALU_ADD     = 4'd1,
    ALU_SUB     = 4'd2,
    ALU_AND     = 4'd3,
    ALU_OR      = 4'd4,
    ALU_XOR     = 4'd5,
    ALU_SLL     = 4'd6,
    ALU_SRL     = 4'd7,
    ALU_SRA     = 4'd8,
    ALU_SLT     = 4'd9,
    ALU_SLTU    = 4'd10,
    ALU_ADDW    = 4'd11,
    ALU_SUBW    = 4'd12,
    ALU_SLLW    = 4'd13,
    ALU_SRLW    = 4'd14,
    ALU_SRAW    = 4'd15
  } alu_op_enum;

  typedef struct packed {
    data_t      a;
    data_t      b;
    alu_op_enum op;
  } alu_req_t;

  function automatic data_t sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Word ops compute on the low 32 bits and sign-extend bit 31 of the result.
  function automatic data_t alu_eval(input alu_req_t r);
    data_t       res;
    logic [31:0] w;
    res = '0;
    w   = '0;
    case (r.op)
      ALU_ADD:  res = r.a + r.b;
      ALU_SUB:  res = r.a - r.b;
      ALU_AND:  res = r.a & r.b;
      ALU_OR:   res = r.a | r.b;
      ALU_XOR:  res = r.a ^ r.b;
      ALU_SLL:  res = r.a << r.b[5:0];
      ALU_SRL:  res = r.a >> r.b[5:0];
      ALU_SRA:  res = $signed(r.a) >>> r.b[5:0];
      ALU_SLT:  res = {63'd0, ($signed(r.a) < $signed(r.b))};
      ALU_SLTU: res = {63'd0, (r.a < r.b)};
      ALU_ADDW: begin
        w   = r.a[31:0] + r.b[31:0];
        res = sext32(w);
      end
      ALU_SUBW: begin
        w   = r.a[31:0] - r.b[31:0];
        res = sext32(w);
      end
      ALU_SLLW: begin
        w   = r.a[31:0] << r.b[4:0];
        res = sext32(w);
      end
      ALU_SRLW: begin
        w   = r.a[31:0] >> r.b[4:0];
        res = sext32(w);
      end
      ALU_SRAW: begin
        w   = $signed(r.a[31:0]) >>> r.b[4:0];
        res = sext32(w);
      end
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last granted index,
// pointer moves only when a grant is actually taken.
module rr_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last;
  logic [PW-1:0] gnt_idx;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if ((gnt == '0) && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

  // Reset to N-1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= PW'(N - 1);
    end else if (advance && (gnt != '0)) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one core ALU between N_REQ requesters: round-robin grant, operand register,
// ALU, result register, tagged valid/ready response with full backpressure and flush.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic       [N_REQ-1:0]  req_valid,
  output logic       [N_REQ-1:0]  req_ready,
  input  data_t      [N_REQ-1:0]  req_a,
  input  data_t      [N_REQ-1:0]  req_b,
  input  alu_op_enum [N_REQ-1:0]  req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output data_t                   rsp_data,
  output logic       [ID_W-1:0]   rsp_id,
  output logic                    busy
);

  logic             op_vld;
  alu_req_t         op_q;
  logic [ID_W-1:0]  op_id;
  logic             rsp_vld;
  data_t            rsp_q;
  logic [ID_W-1:0]  rsp_id_q;

  logic             rsp_stage_free;
  logic             op_stage_free;
  logic             arb_en;
  logic             accept;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  data_t            alu_res;

  assign rsp_stage_free = !rsp_vld || rsp_ready;
  assign op_stage_free  = !op_vld || rsp_stage_free;

  // Flush wins over any simultaneous request; nothing is granted while in reset.
  assign arb_en  = op_stage_free && !flush && !rst;
  assign arb_req = req_valid & {N_REQ{arb_en}};

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (accept),
    .gnt     (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
    end
  end

  assign alu_res = alu_eval(op_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_vld <= 1'b0;
      op_q   <= '0;
      op_id  <= '0;
    end else if (flush) begin
      op_vld <= 1'b0;
    end else if (accept) begin
      op_vld <= 1'b1;
      op_q   <= '{a: req_a[gnt_id], b: req_b[gnt_id], op: req_op[gnt_id]};
      op_id  <= gnt_id;
    end else if (rsp_stage_free) begin
      op_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld  <= 1'b0;
      rsp_q    <= '0;
      rsp_id_q <= '0;
    end else if (flush) begin
      rsp_vld <= 1'b0;
    end else if (op_vld && rsp_stage_free) begin
      rsp_vld  <= 1'b1;
      rsp_q    <= alu_res;
      rsp_id_q <= op_id;
    end else if (rsp_ready) begin
      rsp_vld <= 1'b0;
    end
  end

  assign rsp_valid = rsp_vld;
  assign rsp_data  = rsp_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = op_vld | rsp_vld;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: ALU vector table, grant/occupancy reference model,
// in-order response scoreboard and hand-written backpressure/flush/reset sequences.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int N_REQ = 2;
  localparam int ID_W  = 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   flush = 1'b0;
  logic       [N_REQ-1:0] req_valid = '0;
  logic       [N_REQ-1:0] req_ready;
  data_t      [N_REQ-1:0] req_a = '0;
  data_t      [N_REQ-1:0] req_b = '0;
  alu_op_enum [N_REQ-1:0] req_op;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  data_t                  rsp_data;
  logic       [ID_W-1:0]  rsp_id;
  logic                   busy;

  alu_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0] id;
    data_t           data;
  } exp_t;

  typedef struct {
    int         rq;
    alu_op_enum op;
    data_t      a;
    data_t      b;
    data_t      exp;
  } vec_t;

  exp_t  sb[$];
  int    acc_log[$];
  data_t exp_res [N_REQ];
  vec_t  vecs [17];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input data_t act, input data_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model of pipeline occupancy and round-robin pointer.
  logic             m_op = 1'b0;
  logic             m_rsp = 1'b0;
  int               m_last = N_REQ - 1;
  logic             rsf, osf;
  logic [N_REQ-1:0] exp_rdy;
  int               ai;
  int               sidx;
  logic             held_v = 1'b0;
  data_t            held_d;
  logic [ID_W-1:0]  held_id;
  exp_t             e_pop;

  always @(negedge clk) begin
    if (rst) begin
      m_op   = 1'b0;
      m_rsp  = 1'b0;
      m_last = N_REQ - 1;
      held_v = 1'b0;
      sb.delete();
    end else begin
      rsf     = !m_rsp || rsp_ready;
      osf     = !m_op || rsf;
      exp_rdy = '0;
      ai      = -1;
      if (osf && !flush) begin
        for (int k = 1; k <= N_REQ; k++) begin
          sidx = (m_last + k) % N_REQ;
          if (ai < 0 && req_valid[sidx]) begin
            ai            = sidx;
            exp_rdy[sidx] = 1'b1;
          end
        end
      end
      chk("req_ready", data_t'(req_ready), data_t'(exp_rdy));
      chk("rsp_valid", data_t'(rsp_valid), data_t'(m_rsp));
      chk("busy", data_t'(busy), data_t'(m_op | m_rsp));
      if (held_v) begin
        chk("hold_data", rsp_data, held_d);
        chk("hold_id", data_t'(rsp_id), data_t'(held_id));
      end
      held_v  = rsp_valid && !rsp_ready;
      held_d  = rsp_data;
      held_id = rsp_id;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", data_t'(1), data_t'(0));
        end else begin
          e_pop = sb.pop_front();
          chk("rsp_data", rsp_data, e_pop.data);
          chk("rsp_id", data_t'(rsp_id), data_t'(e_pop.id));
        end
      end
      if (flush) begin
        sb.delete();
        m_op   = 1'b0;
        m_rsp  = 1'b0;
        held_v = 1'b0;
      end else begin
        if (ai >= 0) begin
          sb.push_back('{id: ID_W'(ai), data: exp_res[ai]});
          acc_log.push_back(ai);
          m_last = ai;
        end
        if (m_op && rsf) m_rsp = 1'b1;
        else if (rsp_ready) m_rsp = 1'b0;
        if (ai >= 0) m_op = 1'b1;
        else if (rsf) m_op = 1'b0;
      end
    end
  end

  task automatic issue(input int id, input alu_op_enum op, input data_t a, input data_t b,
                       input data_t exp, output int waited);
    int k;
    logic got;
    req_a[id]   = a;
    req_b[id]   = b;
    req_op[id]  = op;
    exp_res[id] = exp;
    req_valid[id] = 1'b1;
    got = 1'b0;
    for (k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready[id];
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
    waited = k - 1;
    if (!got) chk("issue_timeout", data_t'(0), data_t'(1));
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    chk(name, data_t'(k >= 60), data_t'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0]  = '{0, ALU_ADD,     64'd5, 64'd7, 64'd12};
    vecs[1]  = '{0, ALU_SUB,     64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2]  = '{1, ALU_AND,     64'hF0F0, 64'hFF00, 64'hF000};
    vecs[3]  = '{0, ALU_OR,      64'hF0F0, 64'h0F0F, 64'hFFFF};
    vecs[4]  = '{1, ALU_XOR,     64'hFF, 64'h0F, 64'hF0};
    vecs[5]  = '{0, ALU_SLL,     64'd1, 64'h41, 64'd2};
    vecs[6]  = '{0, ALU_SRL,     64'h8000_0000_0000_0000, 64'd63, 64'd1};
    vecs[7]  = '{0, ALU_SRA,     64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8]  = '{1, ALU_SLT,     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
    vecs[9]  = '{1, ALU_SLTU,    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    vecs[10] = '{0, ALU_SUBW,    64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[11] = '{1, ALU_SLLW,    64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000};
    vecs[12] = '{0, ALU_SRLW,    64'hFFFF_FFFF_8000_0000, 64'h21, 64'h0000_0000_4000_0000};
    vecs[13] = '{1, ALU_SRAW,    64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000};
    vecs[14] = '{0, ALU_DEFAULT, 64'd5, 64'd7, 64'd0};
    vecs[15] = '{0, ALU_ADD,     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    vecs[16] = '{1, ALU_ADDW,    64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};
    for (int i = 0; i < N_REQ; i++) begin
      req_op[i]  = ALU_DEFAULT;
      exp_res[i] = '0;
    end

    // Reset values, with requests pending that must not be granted.
    #1 rst = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_rsp_valid", data_t'(rsp_valid), data_t'(0));
    chk("rst_busy", data_t'(busy), data_t'(0));
    chk("rst_rsp_data", rsp_data, data_t'(0));
    chk("rst_rsp_id", data_t'(rsp_id), data_t'(0));
    chk("rst_req_ready", data_t'(req_ready), data_t'(0));
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Single ADD: granted in the same cycle, response two edges after the request cycle.
    issue(vecs[0].rq, vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].exp, w);
    chk("t1_grant_wait", data_t'(w), data_t'(0));
    @(negedge clk);
    chk("t1_not_yet", data_t'(rsp_valid), data_t'(0));
    @(negedge clk);
    chk("t1_valid", data_t'(rsp_valid), data_t'(1));
    chk("t1_data", rsp_data, data_t'(12));
    chk("t1_id", data_t'(rsp_id), data_t'(0));
    @(posedge clk); #1;

    // ALU vector table, back-to-back.
    for (int v = 1; v < 17; v++) begin
      issue(vecs[v].rq, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp, w);
    end
    drain("t3_drain");

    // Both requesters continuously valid: grants alternate starting with 0.
    acc_log.delete();
    req_a[0] = 64'd100; req_b[0] = 64'd1; req_op[0] = ALU_ADD; exp_res[0] = 64'd101;
    req_a[1] = 64'd200; req_b[1] = 64'd2; req_op[1] = ALU_ADD; exp_res[1] = 64'd202;
    req_valid = 2'b11;
    repeat (8) begin @(posedge clk); #1; end
    req_valid = '0;
    chk("t2_accepts", data_t'(acc_log.size()), data_t'(8));
    for (int i = 0; i < 8 && i < acc_log.size(); i++) begin
      chk("t2_alternate", data_t'(acc_log[i]), data_t'(i % 2));
    end
    drain("t2_drain");

    // Backpressure: two ops in flight, consumer stalled for 5 cycles.
    req_a[0] = 64'd11; req_b[0] = 64'd22; exp_res[0] = 64'd33;
    req_a[1] = 64'd40; req_b[1] = 64'd4;  exp_res[1] = 64'd44;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_ready_low", data_t'(req_ready), data_t'(0));
      chk("t4_inflight", data_t'(sb.size()), data_t'(2));
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain("t4_drain");

    // Flush with both stages full and req0 still requesting.
    req_a[0] = 64'd10; req_b[0] = 64'd20; exp_res[0] = 64'd30;
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_ready", data_t'(req_ready[0]), data_t'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t5_rsp_valid", data_t'(rsp_valid), data_t'(0));
    chk("t5_busy", data_t'(busy), data_t'(0));
    @(negedge clk);
    chk("t5_after_ready", data_t'(req_ready[0]), data_t'(1));
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    drain("t5_drain");

    // Asynchronous reset mid-stream, then first contention goes to req0.
    req_valid = 2'b11;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("t6_rsp_valid", data_t'(rsp_valid), data_t'(0));
    chk("t6_busy", data_t'(busy), data_t'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_first_grant", data_t'(req_ready), data_t'(2'b01));
    @(posedge clk); #1;
    req_valid = '0;
    drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational core ALU instance between N_REQ requesters, e.g. the main execute path, a CSR read-modify-write sequencer and an address-generation helper. Each requester uses a valid/ready request channel. The block arbitrates round-robin, registers the operands, evaluates them in the ALU, and returns a tagged result on one shared valid/ready response channel. It is a 2-stage pipeline (operand stage, result stage) with full backpressure and a synchronous flush.

Parameters:
N_REQ, 2, number of requesters; legal range 2..4
ID_W, $clog2(N_REQ), width of the requester tag on the response

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous kill of all in-flight operations
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester request accepted (one-hot or zero)
req_a  input  N_REQ x 64  operand a per requester (CorePack::data_t)
req_b  input  N_REQ x 64  operand b per requester (CorePack::data_t)
req_op  input  N_REQ x alu_op_enum  operation per requester
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_data  output  64  ALU result
rsp_id  output  ID_W  index of the requester that issued the operation
busy  output  1  either pipeline stage occupied

Behaviour:
- Reset (async, rst=1): op_vld=0, rsp_vld=0, rsp_data=0, rsp_id=0, req_ready=0, busy=0. Round-robin last-grant pointer = N_REQ-1, so requester 0 has first priority.
- Stage advance:
  - rsp_stage_free = !rsp_vld | rsp_ready.
  - op_stage_free = !op_vld | rsp_stage_free.
- Grant (combinational):
  - If op_stage_free and !flush, grant the first asserted req_valid searching from (last+1) mod N_REQ upward with wrap.
  - req_ready = one-hot grant; all zero when nothing is granted.
  - req_ready never depends on rsp_ready through more than the stage-free terms above.
- Accept: on req_valid[i] & req_ready[i], the operand register captures a, b, op and id=i at the clock edge; op_vld=1; last=i.
- Result stage: when op_vld & rsp_stage_free, the result register loads the ALU output and id; rsp_vld=1.
  - Latency: request accept at edge T gives rsp_valid high after edge T+1.
  - Throughput: 1 op/cycle with rsp_ready held high.
- Drain: rsp_vld clears on rsp_ready when no new op moves in.
- Backpressure:
  - rsp_valid, rsp_data and rsp_id stay stable while rsp_valid & !rsp_ready.
  - With both stages full and rsp_ready=0, all req_ready=0.
- Arithmetic: results exactly as the core ALU defines them.
  - *W ops sign-extend bit 31.
  - SLL/SRL/SRA use b[5:0]; *W shifts use b[4:0].
  - ALU_DEFAULT returns 0.
  - No widening or truncation in this block.
- Flush:
  - At the next edge, op_vld=0 and rsp_vld=0.
  - No request is accepted in the flush cycle (flush beats simultaneous req_valid).
  - Pointer is unchanged.
- Fairness:
  - A continuously asserted requester is granted within N_REQ accepted operations.
  - Pointer updates only on an actual accept.
- Single requester: back-to-back grants every cycle, with no bubble inserted by the arbiter.
- Reset mid-operation: in-flight ops are dropped immediately and outputs return to reset values asynchronously.
- busy = op_vld | rsp_vld.

Decomposition:
- CorePack additions: alu_req_t struct {data_t a; data_t b; alu_op_enum op}, and parameter ALU_ARB_MAX_REQ=4.
- Sub-module rr_arbiter (params N; inputs req, advance; output one-hot gnt; internal last pointer, reset N-1) holds the grant logic.
- The core ALU is instantiated once between the operand and result registers.

Test Plan:
1. Req0 {ADD, a=5, b=7}, rsp_ready=1 → req_ready[0] same cycle; rsp_valid 2 edges later with data=12, id=0.
2. Req0 and req1 valid every cycle, rsp_ready=1 → grants alternate 0,1,0,1; responses {id0,id1,...} on consecutive cycles.
3. Req1 {ADDW, a=0x7FFFFFFF, b=1} → rsp_data=0xFFFFFFFF80000000, id=1; req0 {SRA, a=0x8000000000000000, b=63} → 0xFFFFFFFFFFFFFFFF.
4. Two ops accepted, then rsp_ready=0 for 5 cycles → rsp_data and rsp_id held constant, all req_ready=0 after the pipe fills; release gives in-order delivery with no loss or duplication.
5. Flush asserted with both stages full and req0 valid → next cycle rsp_valid=0, busy=0, req_ready[0]=0 in the flush cycle; req0 is accepted the following cycle.
6. Assert rst asynchronously mid-stream → rsp_valid=0 and busy=0 without a clock edge; the first post-reset contention between req0 and req1 grants req0.
